// File: rtl/multicycle_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Control FSM for a multicycle RISC-V style datapath. Sequences
//                fetch/decode/execute/memory/write-back, guards memory
//                handshakes with a wait-cycle timeout, counts retired
//                instructions and latches a sticky trap with a fault cause.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
    parameter int MEM_TIMEOUT = 8,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_addr_sel,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 mem_to_reg,
    output logic                 pc_src,
    output logic [3:0]           state,
    output logic [INSTRET_W-1:0] instret,
    output logic                 trap,
    output logic [1:0]           trap_cause
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        WB_ALU = 4'd7,
        WB_MEM = 4'd8,
        BRANCH = 4'd9,
        TRAP   = 4'd10
    } state_t;

    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [1:0] c_CAUSE_ILL = 2'b01;
    localparam logic [1:0] c_CAUSE_TMO = 2'b10;
    localparam logic [7:0] c_TIMEOUT   = 8'(MEM_TIMEOUT);

    state_t                 state_q, state_d;
    logic [7:0]             wait_q, wait_d;
    logic [1:0]             cause_q, cause_d;
    logic                   trap_q;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   timeout;
    logic                   waiting;

    // A stalled access has exhausted its budget only if memory is still not ready
    assign timeout = (wait_q == c_TIMEOUT) && !mem_ready;
    assign waiting = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);

    // Next-state, datapath controls, fault cause, retire count and wait counter
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        instret_d    = instret_q;
        wait_d       = wait_q;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        alu_src_a    = 2'd0;
        alu_src_b    = 2'd0;
        alu_op       = 2'b00;
        mem_to_reg   = 1'b0;
        pc_src       = 1'b0;

        case (state_q)
            FETCH: begin
                alu_src_b = 2'd1;
                if (timeout) begin
                    state_d = TRAP;
                    cause_d = c_CAUSE_TMO;
                end else begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end
                end
            end
            DECODE: begin
                // Branch target is computed here from the old PC
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                case (opcode)
                    c_OP_RTYPE:              state_d = EXEC_R;
                    c_OP_ITYPE:              state_d = EXEC_I;
                    c_OP_LOAD, c_OP_STORE:   state_d = ADDR;
                    c_OP_BRANCH:             state_d = BRANCH;
                    default: begin
                        state_d = TRAP;
                        cause_d = c_CAUSE_ILL;
                    end
                endcase
            end
            EXEC_R: begin
                alu_src_a = 2'd1;
                alu_op    = 2'b10;
                state_d   = WB_ALU;
            end
            EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                alu_op    = 2'b10;
                state_d   = WB_ALU;
            end
            ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                state_d   = (opcode == c_OP_LOAD) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                mem_addr_sel = 1'b1;
                if (timeout) begin
                    state_d = TRAP;
                    cause_d = c_CAUSE_TMO;
                end else begin
                    mem_read = 1'b1;
                    if (mem_ready) state_d = WB_MEM;
                end
            end
            MEM_WR: begin
                mem_addr_sel = 1'b1;
                if (timeout) begin
                    state_d = TRAP;
                    cause_d = c_CAUSE_TMO;
                end else begin
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        state_d   = FETCH;
                        instret_d = instret_q + INSTRET_W'(1);
                    end
                end
            end
            WB_ALU: begin
                reg_write = 1'b1;
                state_d   = FETCH;
                instret_d = instret_q + INSTRET_W'(1);
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
                instret_d  = instret_q + INSTRET_W'(1);
            end
            BRANCH: begin
                alu_src_a = 2'd1;
                alu_op    = 2'b01;
                pc_src    = 1'b1;
                pc_write  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
                state_d   = FETCH;
                instret_d = instret_q + INSTRET_W'(1);
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = TRAP;
                cause_d = c_CAUSE_ILL;
            end
        endcase

        // Reset abandons whatever is in flight: no strobe may reach the datapath
        if (!reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end

        if (state_d != state_q) begin
            wait_d = 8'd0;
        end else if (waiting && !mem_ready) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // State, counters and sticky fault registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= FETCH;
            wait_q    <= 8'd0;
            cause_q   <= 2'b00;
            trap_q    <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
            if (state_d == TRAP) trap_q <= 1'b1;
        end
    end

    assign state      = state_q;
    assign instret    = instret_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter: MEM_TIMEOUT, 8, max consecutive cycles waiting for mem_ready before trapping (range 1..255).
REQ-002 Parameter: INSTRET_W, 32, width of the retired-instruction counter.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-005 opcode  input  7  instruction-register bits [6:0].
REQ-006 funct3  input  3  instruction-register bits [14:12].
REQ-007 zero  input  1  ALU zero flag from the datapath.
REQ-008 mem_ready  input  1  memory handshake; the access completes in the cycle in which it is high.
REQ-009 pc_write, ir_write, reg_write, mem_read, mem_write  output  1 each  datapath write and access strobes.
REQ-010 mem_addr_sel  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-011 alu_src_a  output  2  ALU A select: 0=PC, 1=rs1, 2=old PC.
REQ-012 alu_src_b  output  2  ALU B select: 0=rs2, 1=constant 4, 2=immediate.
REQ-013 alu_op  output  2  ALU operation: 00=add, 01=subtract, 10=decode from funct fields.
REQ-014 mem_to_reg, pc_src  output  1 each  write-back select (1=MDR) and PC source (1=ALUOut branch target).
REQ-015 state  output  4  current FSM state, for debug.
REQ-016 instret  output  INSTRET_W  count of retired instructions.
REQ-017 trap  output  1  sticky fault flag; trap_cause  output  2  fault code: 01=illegal opcode, 10=memory timeout.

Function
REQ-018 State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, TRAP=10; codes 11-15 go to TRAP with cause 01.
REQ-019 FETCH: drives mem_read=1, mem_addr_sel=0, alu_src_a=0, alu_src_b=1, alu_op=00; when mem_ready=1, asserts ir_write=1 and pc_write=1 in the same cycle and goes to DECODE; otherwise stays in FETCH.
REQ-020 DECODE: drives alu_src_a=2, alu_src_b=2, alu_op=00 (branch target into ALUOut), then dispatches on opcode: 0110011 to EXEC_R, 0010011 to EXEC_I, 0000011 or 0100011 to ADDR, 1100011 to BRANCH; any other opcode goes to TRAP with cause 01.
REQ-021 EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=10, then WB_ALU. EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=10, then WB_ALU.
REQ-022 ADDR: alu_src_a=1, alu_src_b=2, alu_op=00; goes to MEM_RD for a load, MEM_WR for a store.
REQ-023 MEM_RD: mem_read=1, mem_addr_sel=1; goes to WB_MEM on mem_ready=1. MEM_WR: mem_write=1, mem_addr_sel=1; goes to FETCH on mem_ready=1.
REQ-024 WB_ALU: reg_write=1, mem_to_reg=0. WB_MEM: reg_write=1, mem_to_reg=1. Both go to FETCH.
REQ-025 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=01, pc_src=1.
- pc_write = (funct3==000 & zero) | (funct3==001 & ~zero).
- Any other funct3 means not taken.
- Always goes to FETCH.
REQ-026 Output timing: all outputs not listed for a state are 0 in that state. Outputs are combinational from state, except the gating on mem_ready (REQ-019, REQ-023) and on zero/funct3 (REQ-025).
REQ-027 Wait counter: an 8-bit counter increments on each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0. It clears on any state change.
REQ-028 Timeout: when the wait counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is TRAP with cause 10 and no strobe is asserted in that cycle. If mem_ready=1 in the same cycle, the access completes and the timeout does not fire.
REQ-029 TRAP: all strobes are 0, trap=1, trap_cause is held, and the FSM stays in TRAP until reset.
REQ-030 instret increments by 1 on the edge leaving WB_ALU, WB_MEM or BRANCH, and on the edge leaving MEM_WR when mem_ready=1. It wraps from all-ones to 0 and never saturates.
REQ-031 Nominal latencies with mem_ready held at 1: R/I-type 4 cycles, load 5, store 4, branch 3.

Reset
REQ-032 On any rising edge with reset=0: state=FETCH, instret=0, trap=0, trap_cause=00, wait counter=0.
REQ-033 While reset=0, every strobe output (pc_write, ir_write, reg_write, mem_read, mem_write) is forced to 0 regardless of state.
REQ-034 Reset asserted mid-instruction, including in TRAP, abandons the instruction: no write strobe asserts on that edge and the instruction is not counted.

Verification
REQ-035 add (0110011), mem_ready=1 -> states 0,1,2,7,0; reg_write high for exactly 1 cycle; instret 0 to 1.
REQ-036 lw, mem_ready low for 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles, then WB_MEM with mem_to_reg=1; instret=1 after 8 cycles.
REQ-037 beq with zero=1 and then zero=0 -> pc_write=1 with pc_src=1 in BRANCH for the first, pc_write=0 for the second; bne with zero=0 -> pc_write=1.
REQ-038 opcode 1111111 -> TRAP after DECODE, trap=1, trap_cause=01, all strobes 0, state held for 20 cycles.
REQ-039 MEM_TIMEOUT=8, mem_ready stuck at 0 in FETCH -> TRAP entered on the 9th edge, trap_cause=10; repeat with mem_ready=1 exactly in the 8th wait cycle -> no trap.
REQ-040 reset=0 asserted during MEM_WR with mem_ready=1 -> mem_write=0 that cycle, state=FETCH, instret=0; preload instret to all-ones and retire one instruction -> instret=0.
